mux_tree_pipe: RTL

//   Parametrised, pipelined N:1 multiplexer, N = 2**SEL_W, built as a binary tree of 2:1 selections.
//   One register level per tree level, with a valid/ready handshake at input and output.

---
 rtl/mux_tree_pkg.sv | 17 +
 rtl/mux_tree_pipe_if.sv | 28 ++
 rtl/mux_tree_stage.sv | 61 ++++++
 rtl/mux_tree_pipe.sv | 57 +++++
 4 files changed

// File: rtl/mux_tree_pkg.sv
// Shared sizing helpers for the pipelined N:1 multiplexer tree.
// Channel count and per-level word counts are derived from the select width.
package mux_tree_pkg;

  localparam int MUX_TREE_MAX_SEL_W = 6;

  // Number of input channels for a given select width.
  function automatic int ways(input int sel_w);
    return 1 << sel_w;
  endfunction

  // Number of words produced by tree level k.
  function automatic int level_words(input int sel_w, input int k);
    return 1 << (sel_w - k - 1);
  endfunction

endpackage

// File: rtl/mux_tree_pipe_if.sv
// Valid/ready bus around the multiplexer tree: one input transaction
// (all channels plus a select) and one output transaction (picked word plus echoed select).
interface mux_tree_pipe_if #(
  parameter int DATA_W = 8,
  parameter int SEL_W  = 3
);
  import mux_tree_pkg::*;

  logic [ways(SEL_W)*DATA_W-1:0] in_data;
  logic [SEL_W-1:0]              in_sel;
  logic                          in_valid;
  logic                          in_ready;
  logic [DATA_W-1:0]             out_data;
  logic [SEL_W-1:0]              out_sel;
  logic                          out_valid;
  logic                          out_ready;

  modport master (
    output in_data, in_sel, in_valid, out_ready,
    input  in_ready, out_data, out_sel, out_valid
  );

  modport slave (
    input  in_data, in_sel, in_valid, out_ready,
    output in_ready, out_data, out_sel, out_valid
  );

endinterface

// File: rtl/mux_tree_stage.sv
// One level of the multiplexer tree: WORDS_IN/2 two-way picks steered by sel[LEVEL],
// registered together with the full select and a valid bit, with a bubble-collapsing ready.
module mux_tree_stage
  import mux_tree_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int WORDS_IN = 8,
  parameter int SEL_W    = 3,
  parameter int LEVEL    = 0
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [WORDS_IN*DATA_W-1:0]        in_words,
  input  logic [SEL_W-1:0]                  in_sel,
  input  logic                              in_vld,
  output logic                              in_rdy,
  output logic [(WORDS_IN/2)*DATA_W-1:0]    out_words,
  output logic [SEL_W-1:0]                  out_sel,
  output logic                              out_vld,
  input  logic                              out_rdy
);

  localparam int WORDS_OUT = WORDS_IN / 2;

  logic [WORDS_OUT*DATA_W-1:0] pick_c;
  logic [WORDS_OUT*DATA_W-1:0] data_p0;
  logic [SEL_W-1:0]            sel_p0;
  logic                        vld_p0;

  // Odd word of each adjacent pair wins when this level's select bit is set.
  always_comb begin
    pick_c = '0;
    for (int j = 0; j < WORDS_OUT; j++) begin
      pick_c[j*DATA_W +: DATA_W] = in_sel[LEVEL] ? in_words[(2*j+1)*DATA_W +: DATA_W]
                                                 : in_words[(2*j)*DATA_W +: DATA_W];
    end
  end

  // An empty stage always accepts, which lets later items close up gaps under stall.
  assign in_rdy = !vld_p0 || out_rdy;

  // ---- stage register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0  <= 1'b0;
      data_p0 <= '0;
      sel_p0  <= '0;
    end else if (in_rdy) begin
      vld_p0 <= in_vld;
      if (in_vld) begin
        data_p0 <= pick_c;
        sel_p0  <= in_sel;
      end
    end
  end

  assign out_words = data_p0;
  assign out_sel   = sel_p0;
  assign out_vld   = vld_p0;

endmodule

// File: rtl/mux_tree_pipe.sv
// Pipelined 2**SEL_W:1 multiplexer: SEL_W chained tree levels, one register level each,
// with valid/ready flow control that collapses bubbles under backpressure.
module mux_tree_pipe
  import mux_tree_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int SEL_W  = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  mux_tree_pipe_if.slave bus
);

  localparam int N           = ways(SEL_W);
  localparam int TOTAL_WORDS = 2*N - 1;

  // All level word buses packed back to back: N words, then N/2, ..., then the final word.
  logic [TOTAL_WORDS*DATA_W-1:0] words_c;
  logic [SEL_W-1:0]              sel_c [0:SEL_W];
  logic                          vld_c [0:SEL_W];
  logic                          rdy_c [0:SEL_W];

  assign words_c[N*DATA_W-1:0] = bus.in_data;
  assign sel_c[0]              = bus.in_sel;
  assign vld_c[0]              = bus.in_valid;
  assign bus.in_ready          = rdy_c[0];
  assign rdy_c[SEL_W]          = bus.out_ready;

  for (genvar k = 0; k < SEL_W; k++) begin : gen_lvl
    localparam int WIN     = 2 * level_words(SEL_W, k);
    localparam int OFF_IN  = 2*N - 2*WIN;
    localparam int OFF_OUT = OFF_IN + WIN;

    mux_tree_stage #(
      .DATA_W   (DATA_W),
      .WORDS_IN (WIN),
      .SEL_W    (SEL_W),
      .LEVEL    (k)
    ) u_stage (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_words  (words_c[OFF_IN*DATA_W +: WIN*DATA_W]),
      .in_sel    (sel_c[k]),
      .in_vld    (vld_c[k]),
      .in_rdy    (rdy_c[k]),
      .out_words (words_c[OFF_OUT*DATA_W +: (WIN/2)*DATA_W]),
      .out_sel   (sel_c[k+1]),
      .out_vld   (vld_c[k+1]),
      .out_rdy   (rdy_c[k+1])
    );
  end

  assign bus.out_data  = words_c[(TOTAL_WORDS-1)*DATA_W +: DATA_W];
  assign bus.out_sel   = sel_c[SEL_W];
  assign bus.out_valid = vld_c[SEL_W];

endmodule
